// File: rtl/fifo_sync_p.sv
// fifo_sync_p: single-clock parametrised FIFO with a registered fill count,
// almost-full/almost-empty thresholds, optional first-word-fall-through read,
// overflow/underflow pulses and a synchronous clear.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   srst    synchronous clear, active high, overrides WR/RD
//   WR, D   write request and write data
//   RD, Q   read request and read data
//   empty   no words stored           full    depth words stored
//   aempty  count <= aempty_lvl        afull   count >= afull_lvl
//   count   words stored (0..depth)
//   ovf     one-cycle pulse, write rejected because full
//   udf     one-cycle pulse, read rejected because empty
module fifo_sync_p #(
    parameter int data_width = 8,
    parameter int add_width  = 4,
    parameter int afull_lvl  = 12,
    parameter int aempty_lvl = 2,
    parameter bit fwft       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  srst,
    input  logic                  WR,
    input  logic                  RD,
    input  logic [data_width-1:0] D,
    output logic [data_width-1:0] Q,
    output logic                  empty,
    output logic                  full,
    output logic                  aempty,
    output logic                  afull,
    output logic [add_width:0]    count,
    output logic                  ovf,
    output logic                  udf
);

    localparam int CW = add_width + 1;
    localparam logic [CW-1:0] DEPTH  = CW'(2 ** add_width);
    localparam logic [CW-1:0] AFULL  = CW'(afull_lvl);
    localparam logic [CW-1:0] AEMPTY = CW'(aempty_lvl);

    logic [data_width-1:0] mem [2**add_width];

    logic [CW-1:0]        wr_ptr;
    logic [CW-1:0]        rd_ptr;
    logic [CW-1:0]        wr_ptr_nx;
    logic [CW-1:0]        rd_ptr_nx;
    logic [CW-1:0]        count_nx;
    logic [add_width-1:0] rd_addr;
    logic                 wr_acc;
    logic                 rd_acc;

    assign rd_addr = rd_ptr[add_width-1:0];

    // Requests are judged against the registered flags. Because count always
    // equals wr_ptr - rd_ptr, the next count is the difference of the next
    // pointers, which equals count + wr_acc - rd_acc.
    always_comb begin
        wr_acc    = WR && !full && !srst;
        rd_acc    = RD && !empty && !srst;
        wr_ptr_nx = wr_ptr + CW'(wr_acc);
        rd_ptr_nx = rd_ptr + CW'(rd_acc);
        count_nx  = wr_ptr_nx - rd_ptr_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            aempty <= 1'b1;
            afull  <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            aempty <= 1'b1;
            afull  <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nx;
            rd_ptr <= rd_ptr_nx;
            count  <= count_nx;
            empty  <= (count_nx == '0);
            full   <= (count_nx == DEPTH);
            aempty <= (count_nx <= AEMPTY);
            afull  <= (count_nx >= AFULL);
            ovf    <= WR && full;
            udf    <= RD && empty;
        end
    end

    // Storage is not reset; a write during reset is suppressed so the
    // aborted operation leaves no trace.
    always_ff @(posedge clk) begin
        if (wr_acc && rst_n) begin
            mem[wr_ptr[add_width-1:0]] <= D;
        end
    end

    generate
        if (fwft) begin : g_fwft
            // Head word shown combinationally from the read pointer.
            assign Q = mem[rd_addr];
        end else begin : g_std
            logic [data_width-1:0] q_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (srst) begin
                    q_reg <= '0;
                end else if (rd_acc) begin
                    q_reg <= mem[rd_addr];
                end
            end

            assign Q = q_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_p.sv
// tb_fifo_sync_p: self-checking bench for fifo_sync_p (depth 16), covering
// the standard read mode with a data scoreboard plus a FWFT instance.
module tb_fifo_sync_p;

    logic       clk;
    logic       rst_n;
    logic       srst;
    logic       wr;
    logic       rd;
    logic [7:0] d;
    logic [7:0] q;
    logic       empty;
    logic       full;
    logic       aempty;
    logic       afull;
    logic [4:0] count;
    logic       ovf;
    logic       udf;

    logic       wr_f;
    logic       rd_f;
    logic [7:0] d_f;
    logic [7:0] q_f;
    logic       empty_f;
    logic       full_f;
    logic       aempty_f;
    logic       afull_f;
    logic [4:0] count_f;
    logic       ovf_f;
    logic       udf_f;

    fifo_sync_p #(
        .data_width(8), .add_width(4), .afull_lvl(12),
        .aempty_lvl(2), .fwft(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .srst(srst),
        .WR(wr), .RD(rd), .D(d), .Q(q),
        .empty(empty), .full(full), .aempty(aempty), .afull(afull),
        .count(count), .ovf(ovf), .udf(udf)
    );

    fifo_sync_p #(
        .data_width(8), .add_width(4), .afull_lvl(12),
        .aempty_lvl(2), .fwft(1'b1)
    ) dut_f (
        .clk(clk), .rst_n(rst_n), .srst(srst),
        .WR(wr_f), .RD(rd_f), .D(d_f), .Q(q_f),
        .empty(empty_f), .full(full_f), .aempty(aempty_f), .afull(afull_f),
        .count(count_f), .ovf(ovf_f), .udf(udf_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        bit         rd;
        logic [7:0] d;
        int         cnt;
        bit         afl;
        bit         ful;
        bit         aem;
        bit         emp;
        bit         ov;
        bit         ud;
        bit         qchk;
        logic [7:0] q;
    } vec_t;

    vec_t       vecs[34];
    logic [7:0] sb[$];
    int         mcount;
    logic [7:0] last_q;
    int         checks;
    int         errors;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus on the standard-mode FIFO. Called at a falling
    // edge; checks flags against the count model and Q against the queue.
    task automatic op(input bit w, input bit r, input logic [7:0] dv);
        bit         wacc;
        bit         racc;
        logic [7:0] ev;
        wacc = w && (mcount < 16);
        racc = r && (mcount > 0);
        ev = last_q;
        if (racc) ev = sb.pop_front();
        if (wacc) sb.push_back(dv);
        mcount = mcount + int'(wacc) - int'(racc);
        wr = w;
        rd = r;
        d = dv;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        chk("count", count, mcount);
        chk("empty", empty, mcount == 0);
        chk("full", full, mcount == 16);
        chk("aempty", aempty, mcount <= 2);
        chk("afull", afull, mcount >= 12);
        chk("ovf", ovf, w && !wacc);
        chk("udf", udf, r && !racc);
        chk("q", q, ev);
        last_q = ev;
    endtask

    task automatic model_clear();
        mcount = 0;
        sb.delete();
        last_q = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        checks = 0;
        errors = 0;
        model_clear();

        for (int i = 0; i < 17; i++) begin
            c = (i < 16) ? i + 1 : 16;
            vecs[i] = '{1'b1, 1'b0, 8'(i), c, c >= 12, c == 16,
                        c <= 2, 1'b0, i == 16, 1'b0, 1'b0, 8'h00};
        end
        for (int i = 0; i < 17; i++) begin
            c = (i < 16) ? 15 - i : 0;
            vecs[17+i] = '{1'b0, 1'b1, 8'h00, c, c >= 12, c == 16,
                           c <= 2, c == 0, 1'b0, i == 16, 1'b1,
                           (i < 16) ? 8'(i) : 8'h0F};
        end

        rst_n = 1'b0;
        srst = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
        d = 8'h00;
        wr_f = 1'b0;
        rd_f = 1'b0;
        d_f = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", aempty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", afull, 0);
        chk("rst_q", q, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_udf", udf, 0);

        // FWFT: head word visible right after the write edge.
        wr_f = 1'b1;
        d_f = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        wr_f = 1'b0;
        chk("fw_empty", empty_f, 0);
        chk("fw_q", q_f, 8'h3C);
        chk("fw_count", count_f, 1);
        @(posedge clk);
        @(negedge clk);
        chk("fw_q_hold", q_f, 8'h3C);
        rd_f = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_f = 1'b0;
        chk("fw_empty_rd", empty_f, 1);
        chk("fw_count_rd", count_f, 0);
        wr_f = 1'b1;
        d_f = 8'h11;
        @(posedge clk);
        @(negedge clk);
        chk("fw_q_11", q_f, 8'h11);
        d_f = 8'h22;
        @(posedge clk);
        @(negedge clk);
        wr_f = 1'b0;
        chk("fw_q_head", q_f, 8'h11);
        rd_f = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_f = 1'b0;
        chk("fw_q_adv", q_f, 8'h22);
        chk("fw_empty_1", empty_f, 0);

        // Table: fill 0x00..0x0F plus one overflow, then drain plus underflow.
        for (int i = 0; i < 34; i++) begin
            op(vecs[i].wr, vecs[i].rd, vecs[i].d);
            chk("vec_cnt", count, vecs[i].cnt);
            chk("vec_afull", afull, vecs[i].afl);
            chk("vec_full", full, vecs[i].ful);
            chk("vec_aempty", aempty, vecs[i].aem);
            chk("vec_empty", empty, vecs[i].emp);
            chk("vec_ovf", ovf, vecs[i].ov);
            chk("vec_udf", udf, vecs[i].ud);
            if (vecs[i].qchk) chk("vec_q", q, vecs[i].q);
        end

        // Simultaneous WR+RD while full: read wins, 0xAA dropped.
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(8'h10 + i));
        op(1'b1, 1'b1, 8'hAA);
        chk("full_rw_cnt", count, 15);
        chk("full_rw_ovf", ovf, 1);
        for (int i = 0; i < 15; i++) op(1'b0, 1'b1, 8'h00);

        // Simultaneous WR+RD while empty: write wins.
        op(1'b1, 1'b1, 8'h55);
        chk("empty_rw_cnt", count, 1);
        chk("empty_rw_udf", udf, 1);
        op(1'b0, 1'b1, 8'h00);
        chk("empty_rw_q", q, 8'h55);

        // Steady WR+RD at count 5 across pointer wrap.
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 100; i++) begin
            op(1'b1, 1'b1, 8'(8'h85 + i));
            chk("wrap_cnt", count, 5);
        end

        // Synchronous clear with a write pending at count 7.
        op(1'b1, 1'b0, 8'hE0);
        op(1'b1, 1'b0, 8'hE1);
        chk("pre_srst_cnt", count, 7);
        srst = 1'b1;
        wr = 1'b1;
        d = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        srst = 1'b0;
        wr = 1'b0;
        model_clear();
        chk("srst_cnt", count, 0);
        chk("srst_empty", empty, 1);
        chk("srst_ovf", ovf, 0);
        chk("srst_udf", udf, 0);
        chk("srst_q", q, 0);
        op(1'b0, 1'b1, 8'h00);

        // Asynchronous reset between edges at count 9.
        for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 8'(8'hC0 + i));
        op(1'b0, 1'b1, 8'h00);
        chk("pre_rst_cnt", count, 9);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cnt", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_q", q, 0);
        chk("arst_full", full, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        model_clear();
        op(1'b1, 1'b0, 8'h77);
        op(1'b0, 1'b1, 8'h00);
        chk("post_rst_q", q, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sync_p.md
# fifo_sync_p

Single-clock, parametrised FIFO for buffering data between blocks that share a clock domain. It generalises the team's FIFO in three ways: depth is set by an address-width parameter, it adds a registered fill count with programmable almost-full/almost-empty thresholds, and it has a selectable first-word-fall-through read mode. It also reports overflow and underflow, and provides a synchronous clear.

## Interface
Parameters:
- data_width, 8, width of D and Q
- add_width, 4, address bits; depth = 2**add_width (range 2..12)
- afull_lvl, 12, afull asserted when count >= afull_lvl (1..depth)
- aempty_lvl, 2, aempty asserted when count <= aempty_lvl (0..depth-1)
- fwft, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- srst  in  1  synchronous clear, active high
- WR  in  1  write request
- RD  in  1  read request
- D  in  data_width  write data
- Q  out  data_width  read data
- empty  out  1  no words stored
- full  out  1  depth words stored
- aempty  out  1  count <= aempty_lvl
- afull  out  1  count >= afull_lvl
- count  out  add_width+1  words stored, 0..depth
- ovf  out  1  one-cycle pulse: write rejected because full
- udf  out  1  one-cycle pulse: read rejected because empty

## Operation
- Storage: 2**add_width x data_width RAM. wr_ptr and rd_ptr are add_width+1 bits wide; the low add_width bits address the RAM.
- Accepted write: WR=1 and full=0. D is stored at wr_ptr; wr_ptr increments.
- Accepted read: RD=1 and empty=0. rd_ptr increments.
- Simultaneous requests are judged against the pre-edge flags:
  - Full: the read is accepted, the write is rejected, and ovf pulses.
  - Empty: the write is accepted, the read is rejected, and udf pulses.
  - Otherwise both are accepted and count is unchanged.
- count_next = count + wr_acc - rd_acc. All flags are registered and computed from count_next, so they always agree with count in the same cycle.
- empty = (count==0); full = (count==depth).
- Pointers wrap naturally modulo 2**(add_width+1). No special handling is required at wrap-around.
- Standard mode (fwft=0): on an accepted read, Q loads RAM[rd_ptr] at that edge. Otherwise Q holds its value.
- FWFT mode (fwft=1): Q continuously shows RAM[rd_ptr], i.e. the head word, and is valid whenever empty=0. An accepted read advances Q to the next word. Q is undefined while empty=1; the bench must not check it then.
- srst=1 has priority over WR and RD:
  - Pointers, count and ovf/udf clear; flags return to their reset values; Q is cleared to 0 in standard mode.
  - Any WR or RD in that cycle is ignored and produces no ovf/udf.
  - RAM contents are not cleared.
- rst_n=0 clears the same registers immediately, regardless of clk, and aborts any operation in progress.

## Timing
- Reset values: empty=1, full=0, aempty=1, afull=0, count=0, ovf=0, udf=0, Q=0 (standard mode).
- Write at edge k: count, empty, aempty, afull and full update at edge k. In FWFT mode, Q is valid after edge k.
- Read latency, standard mode: RD sampled at edge k gives Q valid after edge k (one clock).
- ovf/udf assert for exactly the one cycle following the rejected request. They are not sticky.
- Back-to-back: one write and one read per clock are sustained indefinitely.
- Release of rst_n is asynchronous. The first accepted write can occur at the first rising edge after rst_n goes high.

## Test plan
- Reset and fill (depth 16, fwft=0): after reset check empty=1, aempty=1, count=0, Q=0. Then write 0x00..0x0F on 16 consecutive clocks:
  - afull rises when count reaches 12.
  - full=1 and count=16 after the 16th write.
  - A 17th WR pulses ovf for one cycle and count stays 16.
- Drain with latency check: from full, hold RD=1 for 16 clocks.
  - Q presents 0x00..0x0F, each one clock after its RD edge.
  - aempty rises at count=2 and empty=1 at count=0.
  - A 17th RD pulses udf and Q holds 0x0F.
- Simultaneous at boundaries:
  - WR+RD while full with D=0xAA: read accepted, ovf=1, count 16->15, 0xAA not stored.
  - WR+RD while empty with D=0x55: count 0->1, udf=1, next read returns 0x55.
- Wrap-around: run 100 cycles of continuous WR+RD with an incrementing pattern at count=5. Require count=5 throughout, the data order preserved, and pointers passing through wrap without a flag glitch.
- FWFT mode: write 0x3C into an empty FIFO. After the write edge, require empty=0 and Q=0x3C with no RD. Then RD gives empty=1 at the next edge.
- Clear and reset mid-operation:
  - srst with WR=1 at count=7 gives count=0 and empty=1, with no ovf/udf.
  - rst_n pulsed low between edges at count=9 gives count=0, empty=1 and Q=0 immediately, before the next edge.
